// File: rtl/id_stage_pipelined_if.sv
// id_stage_pipelined_if: IF/ID slot, WB port, hold/flush controls and ID/EXE slot of the decode stage.
interface id_stage_pipelined_if #(parameter int XLEN = 32);
    logic            in_valid;
    logic [31:0]     in_instr;
    logic [9:0]      in_ctrl;
    logic            wb_en;
    logic [4:0]      wb_dest;
    logic [XLEN-1:0] wb_data;
    logic            hold_in;
    logic            flush;
    logic            stall_out;
    logic            out_valid;
    logic [4:0]      out_dest;
    logic [XLEN-1:0] out_val1;
    logic [XLEN-1:0] out_val2;
    logic [XLEN-1:0] out_reg2;
    logic [9:0]      out_ctrl;
    modport master (
        output in_valid, in_instr, in_ctrl, wb_en, wb_dest, wb_data, hold_in, flush,
        input  stall_out, out_valid, out_dest, out_val1, out_val2, out_reg2, out_ctrl
    );
    modport slave (
        input  in_valid, in_instr, in_ctrl, wb_en, wb_dest, wb_data, hold_in, flush,
        output stall_out, out_valid, out_dest, out_val1, out_val2, out_reg2, out_ctrl
    );
endinterface

// File: rtl/id_stage_pipelined.sv
// id_stage_pipelined: register file with WB bypass, load-use hazard detection and the ID/EXE register.
module id_stage_pipelined #(
    parameter int XLEN     = 32,
    parameter int NUM_REGS = 32
) (
    input logic               clk,
    input logic               rst,
    id_stage_pipelined_if.slave bus
);
    localparam int AW = NUM_REGS > 1 ? $clog2(NUM_REGS) : 1;

    logic [XLEN-1:0] rf [NUM_REGS];
    logic [AW-1:0]   s1, s2, wd, od;
    logic            wb_hit, is_imm, mem_w, haz, unused;
    logic [XLEN-1:0] v1, v2, imm_ext;
    logic signed [15:0] imm;

    logic            valid_q;
    logic [4:0]      dest_q;
    logic [XLEN-1:0] val1_q, val2_q, reg2_q;
    logic [9:0]      ctrl_q;

    assign s1      = bus.in_instr[16 +: AW];
    assign s2      = bus.in_instr[11 +: AW];
    assign wd      = bus.wb_dest[AW-1:0];
    assign od      = dest_q[AW-1:0];
    assign is_imm  = bus.in_ctrl[7];
    assign mem_w   = bus.in_ctrl[5];
    assign imm     = bus.in_instr[15:0];
    assign imm_ext = XLEN'(imm);
    assign unused  = ^{bus.in_instr, bus.wb_dest};

    // A same-cycle WB write wins over the stale array entry.
    assign wb_hit = bus.wb_en && wd != '0;
    assign v1 = s1 == '0 ? '0 : (wb_hit && wd == s1) ? bus.wb_data : rf[s1];
    assign v2 = s2 == '0 ? '0 : (wb_hit && wd == s2) ? bus.wb_data : rf[s2];

    // src2 only matters when it is a real operand or store data.
    assign haz = valid_q && ctrl_q[4] && od != '0 && bus.in_valid &&
                 (od == s1 || (od == s2 && (!is_imm || mem_w)));
    assign bus.stall_out = haz | bus.hold_in;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
        end else if (wb_hit) begin
            rf[wd] <= bus.wb_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst || bus.flush || (!bus.hold_in && (haz || !bus.in_valid))) begin
            valid_q <= 1'b0;
            dest_q  <= '0;
            val1_q  <= '0;
            val2_q  <= '0;
            reg2_q  <= '0;
            ctrl_q  <= '0;
        end else if (!bus.hold_in) begin
            valid_q <= 1'b1;
            dest_q  <= bus.in_instr[25:21];
            val1_q  <= v1;
            val2_q  <= is_imm ? imm_ext : v2;
            reg2_q  <= v2;
            ctrl_q  <= bus.in_ctrl;
        end
    end

    assign bus.out_valid = valid_q;
    assign bus.out_dest  = dest_q;
    assign bus.out_val1  = val1_q;
    assign bus.out_val2  = val2_q;
    assign bus.out_reg2  = reg2_q;
    assign bus.out_ctrl  = ctrl_q;
endmodule
